// File: rtl/vm_pkg.sv
// Shared types and constants for vending_machine_multi.
// Coin codes, FSM state encoding, coin values and the coin decoder.
package vm_pkg;

   typedef enum logic [1:0] {
      COIN_NONE = 2'b00,
      COIN_5    = 2'b01,
      COIN_10   = 2'b10,
      COIN_20   = 2'b11
   } coin_e;

   typedef enum logic [1:0] {
      S_IDLE,
      S_CREDIT,
      S_VEND,
      S_CHANGE
   } state_e;

   localparam int unsigned VAL_5  = 5;
   localparam int unsigned VAL_10 = 10;
   localparam int unsigned VAL_20 = 20;

   // Monetary value of a coin code; the "none" code is worth nothing.
   function automatic int unsigned coin_value(input logic [1:0] code);
      int unsigned v;
      case (code)
         COIN_5:  v = VAL_5;
         COIN_10: v = VAL_10;
         COIN_20: v = VAL_20;
         default: v = 0;
      endcase
      return v;
   endfunction

endpackage

// File: rtl/vm_change_unit.sv
// Change dispenser helper: picks the largest coin not exceeding the
// remaining credit and reports the amount to deduct for it.
module vm_change_unit
   import vm_pkg::*;
#(
   parameter int CREDIT_W = 8
) (
   input  logic [CREDIT_W-1:0] credit,
   output logic [1:0]          coin,
   output logic [CREDIT_W-1:0] dec
);

   // Greedy coin choice: 20, then 10, then 5.
   always_comb begin
      coin = COIN_NONE;
      dec  = '0;
      if (credit >= CREDIT_W'(VAL_20)) begin
         coin = COIN_20;
         dec  = CREDIT_W'(VAL_20);
      end else if (credit >= CREDIT_W'(VAL_10)) begin
         coin = COIN_10;
         dec  = CREDIT_W'(VAL_10);
      end else if (credit >= CREDIT_W'(VAL_5)) begin
         coin = COIN_5;
         dec  = CREDIT_W'(VAL_5);
      end
   end

endmodule

// File: rtl/vending_machine_multi.sv
// Multi-item vending machine: coin credit, item selection, vend pulse and
// coin-by-coin change return. All outputs are registered.
// Optional feature macro: VM_STOCK_EN enables per-item stock counters and
// sold_out tracking; without it stock is unlimited and sold_out is 0.
module vending_machine_multi
   import vm_pkg::*;
#(
   parameter int                            NUM_ITEMS  = 4,
   parameter int                            CREDIT_W   = 8,
   parameter int                            MAX_CREDIT = 60,
   parameter logic [NUM_ITEMS*CREDIT_W-1:0] PRICES     = {8'd25, 8'd20, 8'd15, 8'd10},
   parameter int                            STOCK_INIT = 3,
   localparam int                           SEL_W      = (NUM_ITEMS > 1) ? $clog2(NUM_ITEMS) : 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [1:0]           in,
   input  logic [SEL_W-1:0]     sel,
   input  logic                 sel_valid,
   input  logic                 cancel,
   output logic                 out,
   output logic [SEL_W-1:0]     out_item,
   output logic [1:0]           change,
   output logic                 coin_reject,
   output logic [CREDIT_W-1:0]  credit,
   output logic                 busy,
   output logic [NUM_ITEMS-1:0] sold_out
);

   state_e              state;
   logic [CREDIT_W-1:0] in_value;
   logic [CREDIT_W-1:0] price_sel;
   logic                sel_ok;
   logic                in_stock;
   logic                coin_present;
   logic                coin_fits;
   logic                cancel_go;
   logic                vend_go;
   logic                coin_go;
   logic [1:0]          chg_coin;
   logic [CREDIT_W-1:0] chg_dec;

   vm_change_unit #(
      .CREDIT_W (CREDIT_W)
   ) u_change (
      .credit (credit),
      .coin   (chg_coin),
      .dec    (chg_dec)
   );

   // Decode coin value and selected item price.
   always_comb begin
      in_value  = CREDIT_W'(coin_value(in));
      sel_ok    = (32'(sel) < NUM_ITEMS);
      price_sel = PRICES[32'(sel)*CREDIT_W +: CREDIT_W];
   end

`ifdef VM_STOCK_EN
   localparam int STOCK_W = ($clog2(STOCK_INIT + 1) > 0) ? $clog2(STOCK_INIT + 1) : 1;

   logic [STOCK_W-1:0] stock [NUM_ITEMS];

   // An item can be sold only while its counter is nonzero.
   always_comb begin
      in_stock = sel_ok && (stock[sel] != '0);
   end

   // Stock counters and sold-out flags, updated on the edge that enters VEND.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < NUM_ITEMS; i++) begin
            stock[i] <= STOCK_W'(STOCK_INIT);
         end
         sold_out <= (STOCK_INIT == 0) ? '1 : '0;
      end else if (vend_go) begin
         stock[sel]    <= stock[sel] - STOCK_W'(1);
         sold_out[sel] <= (stock[sel] == STOCK_W'(1));
      end
   end
`else
   // Unlimited stock: nothing is ever sold out.
   always_comb begin
      in_stock = 1'b1;
      sold_out = '0;
   end
`endif

   // Same-cycle arbitration: cancel beats sel_valid beats coin.
   always_comb begin
      coin_present = (in != COIN_NONE);
      coin_fits    = ({1'b0, credit} + {1'b0, in_value}) <= (CREDIT_W+1)'(MAX_CREDIT);
      cancel_go    = (state == S_CREDIT) && cancel;
      vend_go      = (state == S_CREDIT) && !cancel && sel_valid && sel_ok &&
                     in_stock && (credit >= price_sel);
      coin_go      = coin_present && ((state == S_IDLE) || (state == S_CREDIT)) &&
                     !cancel_go && !vend_go && coin_fits;
   end

   // Main FSM with registered outputs; the first change coin is issued on
   // the edge that leaves VEND, so it appears two cycles after sel_valid.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_IDLE;
         credit      <= '0;
         out         <= 1'b0;
         out_item    <= '0;
         change      <= COIN_NONE;
         coin_reject <= 1'b0;
         busy        <= 1'b0;
      end else begin
         out         <= 1'b0;
         out_item    <= '0;
         change      <= COIN_NONE;
         coin_reject <= coin_present && !coin_go;
         case (state)
            S_IDLE: begin
               if (coin_go) begin
                  credit <= credit + in_value;
                  state  <= S_CREDIT;
               end
            end
            S_CREDIT: begin
               if (cancel_go) begin
                  state <= S_CHANGE;
                  busy  <= 1'b1;
               end else if (vend_go) begin
                  state    <= S_VEND;
                  busy     <= 1'b1;
                  out      <= 1'b1;
                  out_item <= sel;
                  credit   <= credit - price_sel;
               end else if (coin_go) begin
                  credit <= credit + in_value;
               end
            end
            S_VEND: begin
               if (credit != '0) begin
                  state  <= S_CHANGE;
                  change <= chg_coin;
                  credit <= credit - chg_dec;
               end else begin
                  state <= S_IDLE;
                  busy  <= 1'b0;
               end
            end
            S_CHANGE: begin
               if (credit != '0) begin
                  change <= chg_coin;
                  credit <= credit - chg_dec;
               end else begin
                  state <= S_IDLE;
                  busy  <= 1'b0;
               end
            end
            default: begin
               state <= S_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
